// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, counter-based debounce FSM,
// registered debounced level plus one-cycle press and release pulses.
module btn_debounce_pulse #(
    parameter int unsigned DB_COUNT = 500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_in_i,
    output logic db_out_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);

    localparam int unsigned CNT_W = $clog2(DB_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, s_q;
    logic             db_q, db_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            s_q       <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_in_i;
            s_q       <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Pulses default low so any pulse lasts exactly the one cycle after its transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        db_d      = db_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_q) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s_q) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_RELEASE: begin
                if (s_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    db_d      = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign db_out_o        = db_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse (DB_COUNT=4): stimulus queues the
// expected pulse type and cycle; a negedge monitor pops and compares each pulse.
module tb_btn_debounce_pulse;

    localparam int unsigned DBC = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    logic btn_in_i;
    logic db_out_o;
    logic press_pulse_o;
    logic release_pulse_o;

    btn_debounce_pulse #(.DB_COUNT(DBC)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .btn_in_i        (btn_in_i),
        .db_out_o        (db_out_o),
        .press_pulse_o   (press_pulse_o),
        .release_pulse_o (release_pulse_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic rel;
        int   cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic rst_edge = 1'b0;
    logic prev_db = 1'b0;
    logic tff_q = 1'b0;
    int   toggles = 0;

    always @(posedge clk_i) begin
        cyc      <= cyc + 1;
        rst_edge <= rst_i;
    end

    // Downstream toggle flip-flop driven by the press pulse.
    always @(posedge clk_i) begin
        if (press_pulse_o === 1'b1) begin
            tff_q   <= ~tff_q;
            toggles <= toggles + 1;
        end
    end

    // Monitor: every pulse seen must match the head of the expected queue.
    always @(negedge clk_i) begin
        if (press_pulse_o === 1'b1 && release_pulse_o === 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL both_pulses: press and release both high at cycle %0d, required at most one", cyc);
        end else if (press_pulse_o === 1'b1 || release_pulse_o === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: %s pulse at cycle %0d, required none",
                         release_pulse_o ? "release" : "press", cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.rel !== release_pulse_o || e.cyc != cyc || db_out_o !== ~e.rel) begin
                    miscompares++;
                    $display("FAIL pulse: got rel=%0b cyc=%0d db=%0b, required rel=%0b cyc=%0d db=%0b",
                             release_pulse_o, cyc, db_out_o, e.rel, e.cyc, ~e.rel);
                end
            end
        end else if (db_out_o !== prev_db && !rst_edge) begin
            vectors++;
            miscompares++;
            $display("FAIL db_change: db changed to %0b at cycle %0d without a pulse, required %0b",
                     db_out_o, cyc, prev_db);
        end
        prev_db = db_out_o;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        btn_in_i = v;
        step(n);
    endtask

    task automatic expect_pulse(input logic rel, input int at);
        ev_t e;
        e.rel = rel;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({db_out_o, press_pulse_o, release_pulse_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s: db/press/release=%b, required 000", name,
                     {db_out_o, press_pulse_o, release_pulse_o});
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    // Press or release with a clean edge: result appears six cycles later.
    task automatic clean_edge(input logic v);
        btn_in_i = v;
        expect_pulse(~v, cyc + 6);
        step(10);
        check_bit(v ? "db_after_press" : "db_after_release", db_out_o, v);
    endtask

    int   t;
    int   tog0;
    logic tff0;

    initial begin
        // Reset held two cycles with the button already pressed
        rst_i    = 1'b1;
        btn_in_i = 1'b1;
        step(1);
        check_zero("reset_a");
        step(1);
        check_zero("reset_b");
        rst_i = 1'b0;
        expect_pulse(1'b0, cyc + 6);
        step(10);
        check_bit("db_after_reset_press", db_out_o, 1'b1);
        clean_edge(1'b0);

        // Clean press and release
        clean_edge(1'b1);
        clean_edge(1'b0);

        // Bounce shorter than the debounce window is rejected
        drive(1'b1, 2);
        drive(1'b0, 1);
        drive(1'b1, 3);
        drive(1'b0, 3);
        check_bit("bounce_db", db_out_o, 1'b0);
        clean_edge(1'b1);

        // Release, then a 3-cycle release glitch while pressed
        clean_edge(1'b0);
        clean_edge(1'b1);
        drive(1'b0, 3);
        btn_in_i = 1'b1;
        step(10);
        check_bit("release_glitch_db", db_out_o, 1'b1);
        clean_edge(1'b0);

        // Reset on the cycle the press pulse is high
        btn_in_i = 1'b1;
        t = cyc;
        expect_pulse(1'b0, t + 6);
        step(6);
        check_bit("pulse_before_reset", press_pulse_o, 1'b1);
        rst_i    = 1'b1;
        btn_in_i = 1'b0;
        step(1);
        check_zero("reset_mid_pulse");
        rst_i = 1'b0;
        step(10);
        check_bit("db_after_mid_pulse_reset", db_out_o, 1'b0);

        // Reset at cnt=2 in WAIT_PRESS; held button restarts a full debounce
        btn_in_i = 1'b1;
        step(4);
        rst_i = 1'b1;
        step(1);
        check_zero("reset_mid_wait");
        step(1);
        rst_i = 1'b0;
        expect_pulse(1'b0, cyc + 6);
        step(10);
        check_bit("db_after_mid_wait_reset", db_out_o, 1'b1);
        clean_edge(1'b0);

        // Three bouncy presses toggle the downstream flip-flop three times
        tog0 = toggles;
        tff0 = tff_q;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1);
            drive(1'b0, 1);
            drive(1'b1, 2);
            drive(1'b0, 2);
            clean_edge(1'b1);
            drive(1'b0, 2);
            drive(1'b1, 1);
            clean_edge(1'b0);
        end
        vectors++;
        if (toggles - tog0 != 3) begin
            miscompares++;
            $display("FAIL tff_toggles: got %0d, required 3", toggles - tog0);
        end
        check_bit("tff_q", tff_q, ~tff0);

        step(5);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
